alu_dr_capture: RTL and testbench
=================================

Name: alu_dr_capture

Overview:
Clocked capture stage directly downstream of the dual-rail ALU. It sequences the ALU's precharge/evaluate cycle, synchronises the ALU `complete` signal, and validates the dual-rail result and zero rails. It then registers them as single-rail values and presents them to the clocked writeback/branch logic over a valid/ready handshake. It is the only block that drives the ALU `precharge` input.

Parameters:
WIDTH, 32, datapath width of result rails
SYNC_STAGES, 2, flops in the `complete` synchroniser (min 2)
PRE_CYCLES, 2, minimum cycles precharge is held before evaluate
TIMEOUT, 64, cycles allowed in EVAL before timeout error

Ports:
clk  in  1  sole clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  issue stage: ALU operands/control stable
in_ready  out  1  block can accept an operation
precharge  out  1  to ALU; 1 = precharge (spacer), 0 = evaluate
alu_result  in  WIDTH  ALU positive result rail
alu_nresult  in  WIDTH  ALU negative result rail
alu_zero  in  1  ALU positive zero rail
alu_nzero  in  1  ALU negative zero rail
alu_complete  in  1  ALU completion (asynchronous)
out_valid  out  1  captured result available
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  captured single-rail result
out_zero  out  1  captured zero flag
out_err  out  2  00 ok, 01 rail violation, 10 timeout, 11 zero mismatch

Behaviour:
- Reset (rst_n=0, async, any state): state=IDLE, precharge=1, in_ready=0 while asserted, out_valid=0, out_result=0, out_zero=0, out_err=00, counters=0, synchroniser cleared. in_ready=1 from the first clock edge after deassertion.
- All outputs registered. `complete` passes through SYNC_STAGES flops (c_s) before use. Rail inputs sampled only when c_s=1; they are monotonic and stable once complete is asserted.
- spacer_ok = all alu_result, alu_nresult, alu_zero, alu_nzero bits 0 and c_s=0.
- FSM:
  - IDLE: precharge=1, in_ready=1. When in_valid&in_ready, go to PRE and clear cnt. in_valid in any other state is ignored (in_ready=0).
  - PRE: precharge=1, cnt++. When cnt>=PRE_CYCLES-1 and spacer_ok, go to EVAL, precharge<=0, cnt<=0. No timeout applies in PRE.
  - EVAL: precharge=0, cnt++.
    - If c_s=1: capture out_result=alu_result and out_zero=alu_zero.
      - out_err=01 if any bit (result or zero pair) has both rails 1 or both rails 0.
      - Else out_err=11 if out_zero != (alu_result==0).
      - Else 00.
      - Go to HOLD with out_valid<=1 and precharge<=1 (the ALU returns to spacer during HOLD).
    - Else if cnt==TIMEOUT-1: out_result=0, out_zero=0, out_err=10, go to HOLD with out_valid<=1 and precharge<=1.
  - HOLD: out_valid=1 and out_result/out_zero/out_err stable until out_ready. On out_valid&out_ready: out_valid<=0, go to IDLE. in_ready stays 0 in HOLD (no overlap).
- Latency from the accept edge to out_valid=1 is (PRE_CYCLES + eval delay + SYNC_STAGES + 1) cycles, minimum. With defaults and instant ALU completion this is 5 cycles.
- out_ready held high before out_valid: transfer occurs on the first out_valid cycle.
- Error output is a status, not a stall: an errored result completes the handshake normally.
- If `complete` and the timeout fire in the same cycle, the capture wins (out_err≠10).
- Reset mid-EVAL/HOLD: out_valid drops immediately and precharge rises immediately; the in-flight result is discarded.

Test Plan:
- Nominal add: rails encode 0x0000_00A5, nrails 0xFFFF_FF5A, zero=0/nzero=1, complete 1 cycle after precharge falls, out_ready=1 → out_valid pulses 1 cycle, out_result=0x000000A5, out_zero=0, out_err=00, latency 5 cycles, precharge=1 in HOLD.
- Zero result: result=0, nresult=0xFFFFFFFF, zero=1 → out_zero=1, out_err=00. Repeat with zero rail=0/nzero=1 → out_err=11.
- Rail violation: bit 7 with both rails 1 at complete → out_err=01, out_result bit7=1, handshake completes. Repeat with bit 3 both 0 → 01.
- Timeout: complete never rises → out_valid at EVAL cycle 64, out_err=10, out_result=0, precharge=1. Next operation then completes normally.
- Backpressure/spacer: out_ready=0 for 10 cycles → out_valid and data stable, in_ready=0, a second in_valid is ignored. In a separate run hold one nresult bit high after precharge → stays in PRE until cleared.
- Async reset asserted mid-EVAL between edges → precharge=1 and out_valid=0 without a clock edge. After release, in_ready=1 and a fresh operation completes correctly.

Source files
------------

// File: rtl/alu_dr_capture.sv
// Capture stage behind the dual-rail ALU: runs the precharge/evaluate cycle, synchronises
// completion, checks the rails and hands a single-rail result downstream over valid/ready.
//
// state | meaning
// IDLE  | ALU in spacer, waiting for an operation
// PRE   | precharge held for PRE_CYCLES and until the rails read as spacer
// EVAL  | ALU evaluating, waiting for synchronised complete or timeout
// HOLD  | result presented, waiting for out_ready

module alu_dr_capture #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int PRE_CYCLES  = 2,
   parameter int TIMEOUT     = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             precharge,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [WIDTH-1:0] alu_nresult,
   input  logic             alu_zero,
   input  logic             alu_nzero,
   input  logic             alu_complete,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic [1:0]       out_err
);

   localparam int CMAX = (TIMEOUT > PRE_CYCLES) ? TIMEOUT : PRE_CYCLES;
   localparam int CW   = ($clog2(CMAX) < 1) ? 1 : $clog2(CMAX);
   localparam logic [CW-1:0] PRE_LOAD  = CW'(PRE_CYCLES - 1);
   localparam logic [CW-1:0] EVAL_LOAD = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_EVAL, S_HOLD} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   precharge_q, precharge_d;
   logic                   in_ready_q, in_ready_d;
   logic                   out_valid_q, out_valid_d;
   logic [WIDTH-1:0]       result_q, result_d;
   logic                   zero_q, zero_d;
   logic [1:0]             err_q, err_d;

   logic c_s;
   logic spacer_ok;
   logic rail_bad;
   logic zero_bad;

   assign c_s       = sync_q[SYNC_STAGES-1];
   assign spacer_ok = ~(|alu_result) & ~(|alu_nresult) & ~alu_zero & ~alu_nzero & ~c_s;
   // a valid dual-rail bit has exactly one rail high
   assign rail_bad  = (|(~(alu_result ^ alu_nresult))) | ~(alu_zero ^ alu_nzero);
   assign zero_bad  = alu_zero != (alu_result == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sync_q      <= '0;
         precharge_q <= 1'b1;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         err_q       <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sync_q      <= {sync_q[SYNC_STAGES-2:0], alu_complete};
         precharge_q <= precharge_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      precharge_d = precharge_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      err_d       = err_q;
      case (state_q)
         S_IDLE: begin
            precharge_d = 1'b1;
            if (in_valid && in_ready_q) begin
               state_d = S_PRE;
               cnt_d   = PRE_LOAD;
            end
         end
         S_PRE: begin
            precharge_d = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (spacer_ok) begin
               state_d     = S_EVAL;
               precharge_d = 1'b0;
               cnt_d       = EVAL_LOAD;
            end
         end
         S_EVAL: begin
            precharge_d = 1'b0;
            // completion is checked first so it wins a tie with the timeout
            if (c_s) begin
               result_d    = alu_result;
               zero_d      = alu_zero;
               err_d       = rail_bad ? 2'b01 : (zero_bad ? 2'b11 : 2'b00);
               out_valid_d = 1'b1;
               precharge_d = 1'b1;
               state_d     = S_HOLD;
            end else if (cnt_q == '0) begin
               result_d    = '0;
               zero_d      = 1'b0;
               err_d       = 2'b10;
               out_valid_d = 1'b1;
               precharge_d = 1'b1;
               state_d     = S_HOLD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_HOLD: begin
            precharge_d = 1'b1;
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready_d = (state_d == S_IDLE);

   assign in_ready   = in_ready_q;
   assign precharge  = precharge_q;
   assign out_valid  = out_valid_q;
   assign out_result = result_q;
   assign out_zero   = zero_q;
   assign out_err    = err_q;

endmodule

// File: tb/tb_alu_dr_capture.sv
// Bench for alu_dr_capture: behavioural dual-rail ALU, directed operations, and a
// scoreboard monitor that checks every transfer on the output handshake.

module tb_alu_dr_capture;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        precharge;
   logic [31:0] alu_result;
   logic [31:0] alu_nresult;
   logic        alu_zero;
   logic        alu_nzero;
   logic        alu_complete;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_zero;
   logic [1:0]  out_err;

   alu_dr_capture #(.WIDTH(32), .SYNC_STAGES(2), .PRE_CYCLES(2), .TIMEOUT(64)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .precharge    (precharge),
      .alu_result   (alu_result),
      .alu_nresult  (alu_nresult),
      .alu_zero     (alu_zero),
      .alu_nzero    (alu_nzero),
      .alu_complete (alu_complete),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_zero     (out_zero),
      .out_err      (out_err)
   );

   typedef struct {
      logic [31:0] r;
      logic        z;
      logic [1:0]  e;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   // ALU model controls, written by the stimulus process only
   logic [31:0] vec_r, vec_nr;
   logic        vec_z, vec_nz;
   bit          respond;
   int          delay;
   logic [31:0] spacer_stuck;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // ALU: spacer while precharged, drives rails and complete 'delay' negedges into evaluate
   initial begin
      int d;
      d = 0;
      alu_result = '0; alu_nresult = '0; alu_zero = 1'b0; alu_nzero = 1'b0; alu_complete = 1'b0;
      forever begin
         @(negedge clk);
         if (precharge !== 1'b0) begin
            alu_result   = '0;
            alu_nresult  = spacer_stuck;
            alu_zero     = 1'b0;
            alu_nzero    = 1'b0;
            alu_complete = 1'b0;
            d = 0;
         end else begin
            if (respond && d == delay) begin
               alu_result   = vec_r;
               alu_nresult  = vec_nr;
               alu_zero     = vec_z;
               alu_nzero    = vec_nz;
               alu_complete = 1'b1;
            end
            if (d < 1000) d++;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output: got result %0h err %0h with nothing expected", out_result, out_err);
            end else begin
               mon_e = sbq.pop_front();
               chk("sb_result", out_result, mon_e.r);
               chk("sb_zero", 32'(out_zero), 32'(mon_e.z));
               chk("sb_err", 32'(out_err), 32'(mon_e.e));
            end
         end
      end
   end

   task automatic run_op(input string nm, input logic [31:0] r, input logic [31:0] nr,
                         input logic z, input logic nz, input bit resp, input int dly,
                         input logic [31:0] er, input logic ez, input logic [1:0] ee,
                         input int elat, input int hold_c, input int stuck_c);
      int n;
      int lat;
      bit ok;
      n = 0;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
      vec_r = r; vec_nr = nr; vec_z = z; vec_nz = nz;
      respond = resp; delay = dly;
      out_ready = (hold_c == 0);
      if (stuck_c > 0) spacer_stuck = 32'h0000_0100;
      sbq.push_back('{r: er, z: ez, e: ee});
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      if (stuck_c > 0) begin
         repeat (stuck_c) @(negedge clk);
         lat += stuck_c;
         chk({nm, "_stuck_precharge"}, 32'(precharge), 32'd1);
         chk({nm, "_stuck_out_valid"}, 32'(out_valid), 32'd0);
         spacer_stuck = '0;
      end
      while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
      chk({nm, "_out_valid"}, 32'(out_valid), 32'd1);
      if (elat >= 0) chk({nm, "_latency"}, 32'(lat), 32'(elat));
      chk({nm, "_precharge_hold"}, 32'(precharge), 32'd1);
      if (hold_c > 0) begin
         ok = 1'b1;
         for (int i = 0; i < hold_c; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            if (out_valid !== 1'b1 || out_result !== er || out_zero !== ez ||
                out_err !== ee || in_ready !== 1'b0 || precharge !== 1'b1) ok = 1'b0;
         end
         chk({nm, "_hold_stable"}, 32'(ok), 32'd1);
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      n = 0;
      while (out_valid && n < 20) begin @(negedge clk); n++; end
      chk({nm, "_handshake"}, 32'(out_valid), 32'd0);
      if (hold_c > 0) begin
         repeat (2) @(negedge clk);
         chk({nm, "_no_extra_accept"}, 32'(in_ready), 32'd1);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      respond = 1'b1;
      delay = 0;
      spacer_stuck = '0;
      vec_r = '0; vec_nr = '0; vec_z = 1'b0; vec_nz = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_precharge", 32'(precharge), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_zero", 32'(out_zero), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      run_op("nominal", 32'h0000_00A5, 32'hFFFF_FF5A, 1'b0, 1'b1, 1'b1, 0,
             32'h0000_00A5, 1'b0, 2'b00, 5, 0, 0);
      run_op("zero", 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 0,
             32'h0, 1'b1, 2'b00, 5, 0, 0);
      run_op("zero_mismatch", 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 0,
             32'h0, 1'b0, 2'b11, 5, 0, 0);
      run_op("rail_both1", 32'h0000_00A5, 32'hFFFF_FFDA, 1'b0, 1'b1, 1'b1, 0,
             32'h0000_00A5, 1'b0, 2'b01, 5, 0, 0);
      run_op("rail_both0", 32'h0000_00A5, 32'hFFFF_FF52, 1'b0, 1'b1, 1'b1, 0,
             32'h0000_00A5, 1'b0, 2'b01, 5, 0, 0);
      run_op("timeout", 32'h1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 0,
             32'h0, 1'b0, 2'b10, 66, 0, 0);
      run_op("after_timeout", 32'h1234_5678, 32'hEDCB_A987, 1'b0, 1'b1, 1'b1, 0,
             32'h1234_5678, 1'b0, 2'b00, 5, 0, 0);
      run_op("tie", 32'h0000_0F00, 32'hFFFF_F0FF, 1'b0, 1'b1, 1'b1, 61,
             32'h0000_0F00, 1'b0, 2'b00, 66, 0, 0);
      run_op("slow_eval", 32'h8000_0001, 32'h7FFF_FFFE, 1'b0, 1'b1, 1'b1, 7,
             32'h8000_0001, 1'b0, 2'b00, 12, 0, 0);
      run_op("backpressure", 32'hCAFE_0001, 32'h3501_FFFE, 1'b0, 1'b1, 1'b1, 0,
             32'hCAFE_0001, 1'b0, 2'b00, 5, 10, 0);
      run_op("spacer_stuck", 32'h0000_0042, 32'hFFFF_FFBD, 1'b0, 1'b1, 1'b1, 0,
             32'h0000_0042, 1'b0, 2'b00, -1, 0, 10);

      // reset between edges while evaluating
      respond = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (precharge && n < 20) begin @(negedge clk); n++; end
      chk("mid_eval_entered", 32'(precharge), 32'd0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_eval_rst_precharge", 32'(precharge), 32'd1);
      chk("mid_eval_rst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_eval_post_in_ready", 32'(in_ready), 32'd1);

      // reset between edges while holding a result
      respond = 1'b1;
      delay = 0;
      vec_r = 32'h5555_5555; vec_nr = 32'hAAAA_AAAA; vec_z = 1'b0; vec_nz = 1'b1;
      out_ready = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      chk("mid_hold_entered", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_hold_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_hold_rst_precharge", 32'(precharge), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("mid_hold_post_in_ready", 32'(in_ready), 32'd1);

      run_op("post_reset", 32'h0000_3C3C, 32'hFFFF_C3C3, 1'b0, 1'b1, 1'b1, 0,
             32'h0000_3C3C, 1'b0, 2'b00, 5, 0, 0);

      repeat (5) @(negedge clk);
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
